// File: rtl/sha256_pkg.sv
// sha256_pkg: shared constants and helper functions for the SHA-256 stream core.
// Optional SHA224_EN macro adds the SHA-224 initial hash value.
package sha256_pkg;

  // FSM encoding kept as plain constants so older blocks can compare against them
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_ROUNDS = 2'd1;
  localparam state_t S_UPDATE = 2'd2;
  localparam state_t S_OUT    = 2'd3;

  // Index 0 is H0 / working var a, so the packed value maps straight onto out_hash
  typedef logic [0:7][31:0] hash_t;

  localparam hash_t SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

`ifdef SHA224_EN
  localparam hash_t SHA224_IV = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
`endif

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round.
// Chained ROUNDS_PER_CYCLE deep inside sha256_stream_core.
module sha256_round
  import sha256_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [31:0] i_c,
  input  logic [31:0] i_d,
  input  logic [31:0] i_e,
  input  logic [31:0] i_f,
  input  logic [31:0] i_g,
  input  logic [31:0] i_h,
  input  logic [31:0] i_k,
  input  logic [31:0] i_w,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic [31:0] o_c,
  output logic [31:0] o_d,
  output logic [31:0] o_e,
  output logic [31:0] o_f,
  output logic [31:0] o_g,
  output logic [31:0] o_h
);
  logic [31:0] w_t1, w_t2;

  // The two temporaries of the round; everything else is a register rename
  always_comb begin
    w_t1 = i_h + big_sigma1(i_e) + ch(i_e, i_f, i_g) + i_k + i_w;
    w_t2 = big_sigma0(i_a) + maj(i_a, i_b, i_c);
  end

  assign o_a = w_t1 + w_t2;
  assign o_b = i_a;
  assign o_c = i_b;
  assign o_d = i_c;
  assign o_e = i_d + w_t1;
  assign o_f = i_e;
  assign o_g = i_f;
  assign o_h = i_g;
endmodule

// File: rtl/sha256_stream_core.sv
// sha256_stream_core: streaming SHA-256 over pre-padded 512-bit blocks with
// intermediate-hash chaining, valid/ready on both sides and a rolling 16-word
// message schedule. ROUNDS_PER_CYCLE (1/2/4) rounds are evaluated per clock.
// Optional SHA224_EN macro adds in_mode224 for SHA-224 digests.
module sha256_stream_core
  import sha256_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic         in_first,
  input  logic         in_last,
`ifdef SHA224_EN
  input  logic         in_mode224,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_hash,
  output logic         busy
);
  localparam int NROUND_CYC = 64 / ROUNDS_PER_CYCLE;
  localparam logic [5:0] LAST_CYC = 6'(NROUND_CYC - 1);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rpc
    $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  state_t            r_state;
  logic [5:0]        r_cnt;
  hash_t             r_h;
  hash_t             r_wv;
  logic [0:15][31:0] r_w;
  logic              r_last;
  logic              r_out_valid;
  logic [255:0]      r_out_hash;

  hash_t             w_iv;
  hash_t             w_sum;
  logic [255:0]      w_digest;
  logic [31:0]       w_ext [0:15+ROUNDS_PER_CYCLE];
  logic [0:15][31:0] w_w_nxt;
  hash_t             w_st [0:ROUNDS_PER_CYCLE];

`ifdef SHA224_EN
  logic r_mode224;
  logic w_mode;
  // Mode is latched with the first block, later blocks reuse it
  assign w_mode   = in_first ? in_mode224 : r_mode224;
  assign w_iv     = w_mode ? SHA224_IV : SHA256_IV;
  assign w_digest = r_mode224 ? {w_sum[0:6], 32'h0} : w_sum;
`else
  assign w_iv     = SHA256_IV;
  assign w_digest = w_sum;
`endif

  // Extend the window by ROUNDS_PER_CYCLE words; later new words depend on
  // earlier ones from the same cycle, so they are built in order
  always_comb begin
    for (int i = 0; i < 16; i++) w_ext[i] = r_w[i];
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++)
      w_ext[16+j] = small_sigma1(w_ext[14+j]) + w_ext[9+j] + small_sigma0(w_ext[1+j]) + w_ext[j];
    for (int i = 0; i < 16; i++) w_w_nxt[i] = w_ext[i+ROUNDS_PER_CYCLE];
  end

  // Chaining sum H + working vars, used by the update state
  always_comb begin
    for (int i = 0; i < 8; i++) w_sum[i] = r_h[i] + r_wv[i];
  end

  assign w_st[0] = r_wv;

  for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_rnd
    logic [31:0] w_k;
    logic [31:0] w_na, w_nb, w_nc, w_nd, w_ne, w_nf, w_ng, w_nh;
    assign w_k = K[r_cnt * 6'(ROUNDS_PER_CYCLE) + 6'(g)];
    sha256_round u_rnd (
      .i_a(w_st[g][0]), .i_b(w_st[g][1]), .i_c(w_st[g][2]), .i_d(w_st[g][3]),
      .i_e(w_st[g][4]), .i_f(w_st[g][5]), .i_g(w_st[g][6]), .i_h(w_st[g][7]),
      .i_k(w_k), .i_w(w_ext[g]),
      .o_a(w_na), .o_b(w_nb), .o_c(w_nc), .o_d(w_nd),
      .o_e(w_ne), .o_f(w_nf), .o_g(w_ng), .o_h(w_nh)
    );
    assign w_st[g+1] = {w_na, w_nb, w_nc, w_nd, w_ne, w_nf, w_ng, w_nh};
  end

  // Control FSM plus all datapath registers; ena low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_h         <= SHA256_IV;
      r_wv        <= '0;
      r_w         <= '0;
      r_last      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_hash  <= '0;
`ifdef SHA224_EN
      r_mode224   <= 1'b0;
`endif
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_wv    <= in_first ? w_iv : r_h;
            if (in_first) r_h <= w_iv;
`ifdef SHA224_EN
            if (in_first) r_mode224 <= in_mode224;
`endif
            r_w     <= in_block;
            r_last  <= in_last;
            r_cnt   <= '0;
            r_state <= S_ROUNDS;
          end
        end
        S_ROUNDS: begin
          r_wv <= w_st[ROUNDS_PER_CYCLE];
          r_w  <= w_w_nxt;
          if (r_cnt == LAST_CYC) begin
            r_cnt   <= '0;
            r_state <= S_UPDATE;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        S_UPDATE: begin
          r_h <= w_sum;
          if (r_last) begin
            r_out_hash  <= w_digest;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = ena && (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_hash  = r_out_hash;
endmodule

// File: tb/tb_sha256_stream_core.sv
// tb_sha256_stream_core: known-answer table, randomized messages against a
// plain SHA-256 reference, and handshake/reset/enable corner sequences.
module tb_sha256_stream_core;
  localparam int RPC   = 1;
  localparam int NRC   = 64 / RPC;
  localparam int LIMIT = 2000;

  typedef logic [7:0]        u8;
  typedef u8                 bq_t[$];
  typedef logic [511:0]      blk_q_t[$];
  typedef logic [0:7][31:0]  h_t;
  typedef struct { string msg; bit m224; int gap; logic [255:0] exp; } kat_t;

  localparam h_t IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                          32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam h_t IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                          32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [255:0] ABC_256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  logic clk = 1'b0;
  logic rst, ena, in_valid, in_ready, in_first, in_last;
  logic out_valid, out_ready, busy;
  logic [511:0] in_block;
  logic [255:0] out_hash;
`ifdef SHA224_EN
  logic in_mode224;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;

  sha256_stream_core #(.ROUNDS_PER_CYCLE(RPC)) dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .in_first(in_first), .in_last(in_last),
`ifdef SHA224_EN
    .in_mode224(in_mode224),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_hash(out_hash), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic h_t compress(input h_t hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    h_t hout;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hin[i];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) hout[i] = hin[i] + v[i];
    return hout;
  endfunction

  function automatic blk_q_t pad(input bq_t msg);
    blk_q_t r;
    u8 pb [$];
    int L, nb;
    logic [63:0] bits;
    logic [511:0] blk;
    L = msg.size();
    nb = (L + 8) / 64 + 1;
    pb = msg;
    pb.push_back(8'h80);
    while (pb.size() < nb * 64 - 8) pb.push_back(8'h00);
    bits = 64'(L) * 64'd8;
    for (int i = 0; i < 8; i++) pb.push_back(bits[63-8*i -: 8]);
    for (int b = 0; b < nb; b++) begin
      for (int i = 0; i < 64; i++) blk[511-8*i -: 8] = pb[b*64+i];
      r.push_back(blk);
    end
    return r;
  endfunction

  function automatic logic [255:0] sha_ref(input bq_t msg, input bit m224);
    blk_q_t blks;
    h_t h;
    blks = pad(msg);
    h = m224 ? IV224 : IV256;
    foreach (blks[b]) h = compress(h, blks[b]);
    if (m224) h[7] = 32'h0;
    return h;
  endfunction

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(u8'(s[i]));
    return q;
  endfunction

  // ---------------- checking / driving ----------------
  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  task automatic put_block(input logic [511:0] blk, input bit f, input bit l, input bit m224,
                           input int gap, input bit watch, inout bit early);
    int n;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
      if (watch && out_valid) early = 1'b1;
    end
    in_block = blk; in_first = f; in_last = l;
`ifdef SHA224_EN
    in_mode224 = m224;
`else
    if (m224) $display("[TB] note: 224 mode requested without SHA224_EN");
`endif
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < LIMIT) begin
      @(posedge clk); #1; n++;
      if (watch && out_valid) early = 1'b1;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [255:0] got, output int lat);
    int n;
    n = 0;
    while (!out_valid && n < LIMIT) begin
      @(posedge clk); #1; n++;
    end
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL out_timeout: out_valid stayed 0 for %0d cycles, required 1", n);
      got = '0; lat = -1;
    end else begin
      got = out_hash;
      lat = cyc - acc_cyc;
    end
  endtask

  task automatic send_msg(input bq_t msg, input bit first, input bit m224, input int gap,
                          output logic [255:0] got, output int lat);
    blk_q_t blks;
    bit early;
    blks = pad(msg);
    early = 1'b0;
    foreach (blks[b])
      put_block(blks[b], first && (b == 0), b == blks.size() - 1, m224, gap, b > 0, early);
    if (blks.size() > 1) chk("no_early_out", 256'(early), 256'(0));
    wait_out(got, lat);
  endtask

  // ---------------- test sequence ----------------
  kat_t kats [$];
  logic [255:0] got, held;
  int lat;
  bq_t msg;
  bit m;
  logic [511:0] abc_blk;
  bit dummy;
  bit seen;

  initial begin
    rst = 1'b1; ena = 1'b1; in_valid = 1'b0; in_block = '0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
`ifdef SHA224_EN
    in_mode224 = 1'b0;
`endif
    kats.push_back('{"abc", 1'b0, 0, ABC_256});
    kats.push_back('{"", 1'b0, 0, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855});
    kats.push_back('{"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 1'b0, 3,
                     256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1});
`ifdef SHA224_EN
    kats.push_back('{"abc", 1'b1, 0, 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000});
`endif
    abc_blk = pad(s2q("abc"))[0];

    repeat (3) @(posedge clk); #1;
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_hash", out_hash, 256'(0));
    rst = 1'b0;

    // known answers, including the two-block message with input gaps
    foreach (kats[i]) begin
      send_msg(s2q(kats[i].msg), 1'b1, kats[i].m224, kats[i].gap, got, lat);
      chk($sformatf("kat%0d_digest", i), got, kats[i].exp);
      chk($sformatf("kat%0d_latency", i), 256'(lat), 256'(NRC + 1));
    end

    // random messages against the reference model
    for (int it = 0; it < 10; it++) begin
      msg = {};
      for (int k = 0, len = $urandom_range(0, 190); k < len; k++) msg.push_back(u8'($urandom));
`ifdef SHA224_EN
      m = 1'($urandom);
`else
      m = 1'b0;
`endif
      send_msg(msg, 1'b1, m, $urandom_range(0, 3), got, lat);
      chk($sformatf("rand%0d_len%0d_digest", it, msg.size()), got, sha_ref(msg, m));
      chk($sformatf("rand%0d_latency", it), 256'(lat), 256'(NRC + 1));
    end

    // output backpressure: result and status held while the consumer stalls
    @(posedge clk); #1;
    out_ready = 1'b0;
    send_msg(s2q("abc"), 1'b1, 1'b0, 0, got, lat);
    chk("bp_digest", got, ABC_256);
    held = got;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid_ready", k), 256'({out_valid, in_ready}), 256'(2'b10));
      chk($sformatf("bp%0d_hash", k), out_hash, held);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_after_valid", 256'(out_valid), 256'(0));
    chk("bp_after_in_ready", 256'(in_ready), 256'(1));
    chk("bp_hash_retained", out_hash, held);

    // reset in the middle of the rounds aborts without a digest
    dummy = 1'b0;
    put_block(abc_blk, 1'b1, 1'b1, 1'b0, 0, 1'b0, dummy);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", 256'(out_valid), 256'(0));
    chk("mid_rst_out_hash", out_hash, 256'(0));
    chk("mid_rst_busy", 256'(busy), 256'(0));
    chk("mid_rst_in_ready", 256'(in_ready), 256'(1));
    rst = 1'b0;
    seen = 1'b0;
    repeat (NRC + 10) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_digest", 256'(seen), 256'(0));

    // first block after reset without in_first chains from the IV
    send_msg(s2q("abc"), 1'b0, 1'b0, 0, got, lat);
    chk("nofirst_digest", got, ABC_256);

    // ena low for 5 cycles during the rounds, then in S_OUT
    @(posedge clk); #1;
    out_ready = 1'b0;
    put_block(abc_blk, 1'b1, 1'b1, 1'b0, 0, 1'b0, dummy);
    repeat (10) @(posedge clk);
    #1 ena = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("ena%0d_ready_busy_valid", k), 256'({in_ready, busy, out_valid}), 256'(3'b010));
    end
    ena = 1'b1;
    wait_out(got, lat);
    chk("ena_digest", got, ABC_256);
    chk("ena_latency", 256'(lat), 256'(NRC + 1 + 5));
    ena = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("ena_out%0d_valid", k), 256'(out_valid), 256'(1));
    end
    ena = 1'b1;
    @(posedge clk); #1;
    chk("ena_out_release_valid", 256'(out_valid), 256'(0));
    chk("ena_out_release_ready", 256'(in_ready), 256'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sha256_stream_core.md
Name: sha256_stream_core

Overview:
- Parametrised successor to the single-block SHA-256 accelerator.
- Hashes messages of arbitrary length as a stream of pre-padded 512-bit blocks, chaining the intermediate hash between blocks.
- Uses valid/ready handshakes on input and output, a rolling 16-word message schedule instead of a 64-word store, and a configurable number of rounds per clock.
- Sits between the padding/DMA front end and the result FIFO of the crypto subsystem.

Parameters:
- ROUNDS_PER_CYCLE, 1: compression rounds per clock. Legal values are 1, 2 and 4; any other value is an elaboration error.
- NROUND_CYC, 64/ROUNDS_PER_CYCLE: derived, not overridable.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- ena  input  1  clock enable; when low, all state freezes
- in_valid  input  1  in_block/in_first/in_last are valid
- in_ready  output  1  core can accept a block
- in_block  input  512  padded message block, word 0 in bits [511:480]
- in_first  input  1  block starts a new message
- in_last  input  1  block ends the message
- out_valid  output  1  out_hash is valid
- out_ready  input  1  consumer accepts out_hash
- out_hash  output  256  digest, H0 in bits [255:224]
- busy  output  1  high in any state other than S_IDLE

Behaviour:
- States: S_IDLE, S_ROUNDS, S_UPDATE, S_OUT.
- Reset values: state S_IDLE; H0..H7 = SHA-256 IV; out_valid 0; out_hash 0; busy 0; in_ready 1; round counter 0.
- in_ready = ena && state==S_IDLE. A block is accepted on a clk edge with in_valid && in_ready.
- On accept:
  - Working vars a..h <= in_first ? IV : H.
  - If in_first, H <= IV.
  - W window[0..15] <= in_block words.
  - last_q <= in_last; round counter <= 0; go to S_ROUNDS.
- S_ROUNDS: each cycle applies ROUNDS_PER_CYCLE rounds.
  - Round t uses K[t] and W[t].
  - For t>=16, W[t] = sigma1(W[t-2]) + W[t-7] + sigma0(W[t-15]) + W[t-16], computed from the window; the window shifts by ROUNDS_PER_CYCLE words per cycle.
  - All additions are mod 2^32.
  - After NROUND_CYC cycles, go to S_UPDATE.
- S_UPDATE (1 cycle): H_i <= H_i + working var i.
  - If last_q: out_hash <= updated H, out_valid <= 1, go to S_OUT.
  - Else: go to S_IDLE and wait for the next block of the same message; H is retained.
- S_OUT: hold out_valid and out_hash stable until out_valid && out_ready at an edge; then out_valid <= 0 and go to S_IDLE.
  - in_ready is therefore high the cycle after the transfer.
- Latency: with the accept edge counted as edge 0, out_valid rises after edge NROUND_CYC+1. That is 65 cycles for R=1, 33 for R=2, 17 for R=4. Block-to-block throughput is NROUND_CYC+2 cycles.
- Boundary conditions:
  - A first-ever block with in_first=0 after reset chains from the IV, because H resets to IV.
  - in_first && in_last together is a single-block message.
  - in_valid during busy is not accepted; the source must hold its data.
  - ena low freezes the state, the counters and the outputs; in_ready is 0; out_valid holds its value.
  - rst mid-operation aborts immediately and restores all reset values. No partial digest is emitted.
  - out_hash is unchanged while out_valid=0, except on reset.

Optional Feature:
- Macro SHA224_EN.
- When defined:
  - Adds input port in_mode224, 1 bit, sampled with an accepted in_first block and held per message.
  - In 224 mode, the IV is the SHA-224 IV and out_hash = {H0..H6, 32'h0}.
- When undefined: the port is absent and the core is SHA-256 only.

Decomposition:
- Package sha256_pkg holds:
  - the state enum;
  - SHA256_IV, plus SHA224_IV under the macro;
  - the K[0:63] constant array;
  - functions big_sigma0/1, small_sigma0/1, ch, maj.
- Sub-module sha256_round: combinational single round. Inputs are a..h, K and W; outputs are the next a..h. It is instantiated ROUNDS_PER_CYCLE times in a chain.
- The schedule window stays in the core.

Test Plan:
- "abc" as a single padded block, first=last=1, R=1 -> ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; out_valid rises 65 cycles after accept.
- Empty message (one block 0x80...0) -> e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- 448-bit "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" as two blocks (first then last), with in_valid gaps of 3 cycles -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1; no out_valid after block 1.
- Backpressure: out_ready low for 10 cycles after the "abc" result -> out_valid=1 and out_hash stable, in_ready=0 throughout; in_ready=1 one cycle after the handshake.
- Reset asserted mid-S_ROUNDS, ena toggled low for 5 cycles during a later "abc" run -> outputs return to reset values; next "abc" digest correct; latency extended by exactly 5 cycles.
- R=4 build, "abc" -> same digest, out_valid 17 cycles after accept. SHA224_EN build, in_mode224=1, "abc" -> 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7 00000000.
